// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM/grant encodings and line alignment helper
package mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int OFF_W = 4;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'((1 << OFF_W) - 1);
  endfunction
endpackage

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: two-way round-robin picker; bit 0 = iCache, bit 1 = dCache
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_t       last,
  output logic [1:0] gnt
);
  always_comb gnt = &req ? (last == GNT_D ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory line port between iCache and dCache, one transaction per grant
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_line,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);
  arb_state_t state;
  gnt_t grant, last_grant;
  logic [1:0] gnt;
  arb_rr2 u_rr (.req({dc_req, ic_req}), .last(last_grant), .gnt(gnt));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      grant <= GNT_I;
      last_grant <= GNT_I;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      ic_line <= '0;
      dc_line <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: if (|gnt) begin
          grant <= gnt[1] ? GNT_D : GNT_I;
          mem_addr <= line_align(gnt[1] ? dc_addr : ic_addr);
          mem_we <= gnt[1] & dc_we;
          mem_wdata <= gnt[1] ? dc_wdata : '0;
          mem_req <= 1'b1;
          busy <= 1'b1;
          state <= ARB_BUSY;
        end
        ARB_BUSY: if (mem_ready) begin
          if (!mem_we && grant == GNT_I) ic_line <= mem_rdata;
          if (!mem_we && grant == GNT_D) dc_line <= mem_rdata;
          ic_ready <= grant == GNT_I;
          dc_ready <= grant == GNT_D;
          mem_req <= 1'b0;
          state <= ARB_DONE;
        end
        default: begin
          ic_ready <= 1'b0;
          dc_ready <= 1'b0;
          last_grant <= grant;
          busy <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and randomized traffic against a transaction-level model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 0, rst = 0;
  logic ic_req = 0, dc_req = 0, dc_we = 0, mem_ready = 0;
  logic [31:0] ic_addr = 0, dc_addr = 0;
  logic [127:0] dc_wdata = 0, mem_rdata = 0;
  logic ic_ready, dc_ready, mem_req, mem_we, busy;
  logic [127:0] ic_line, dc_line, mem_wdata;
  logic [31:0] mem_addr;
  mem_arbiter dut (.clk(clk), .rst(rst), .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready),
    .ic_line(ic_line), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_line(dc_line), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy));
  always #5 clk = ~clk;
  int n_cmp = 0, n_fail = 0;
  int mem_lat = 0, mem_cnt = 0;
  logic mem_sent = 0, spur = 0;
  logic [127:0] mem_line = 0;
  logic m_last = 0;
  logic [127:0] m_ic_line = 0, m_dc_line = 0;
  // Memory model: completes L cycles after the first cycle it sees mem_req; spur drives junk completions while idle
  always @(negedge clk) begin
    mem_ready = 0;
    if (!mem_req) begin
      mem_cnt = 0;
      mem_sent = 0;
      mem_ready = spur;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end else if (!mem_sent) begin
      if (mem_cnt == mem_lat) begin
        mem_ready = 1;
        mem_rdata = mem_line;
        mem_sent = 1;
      end else mem_cnt++;
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic txn(input logic ic, input logic dc, input logic we, input logic [31:0] ia,
                     input logic [31:0] da, input logic [127:0] wd, input logic [127:0] rd,
                     input int lat, input logic exp_d, input logic [31:0] exp_addr, input logic exp_we);
    int n;
    ic_req = ic; dc_req = dc; dc_we = we; ic_addr = ia; dc_addr = da; dc_wdata = wd;
    mem_lat = lat; mem_line = rd;
    n = 0;
    while (!mem_req && n < 8) begin @(negedge clk); n++; end
    chk("grant_latency", n, 1);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_we", mem_we, exp_we);
    if (exp_we) chk("mem_wdata", mem_wdata, wd);
    if (exp_d) begin dc_addr = ~da; dc_wdata = ~wd; end else ic_addr = ~ia;
    n = 0;
    while (!(ic_ready || dc_ready) && n < lat + 8) begin @(negedge clk); n++; end
    chk("ready_latency", n, lat + 1);
    chk("mem_addr_hold", mem_addr, exp_addr);
    chk("ic_ready", ic_ready, !exp_d);
    chk("dc_ready", dc_ready, exp_d);
    if (!exp_we) begin
      if (exp_d) m_dc_line = rd; else m_ic_line = rd;
    end
    chk("ic_line", ic_line, m_ic_line);
    chk("dc_line", dc_line, m_dc_line);
    m_last = exp_d;
    if (exp_d) dc_req = 0; else ic_req = 0;
    @(negedge clk);
    chk("ready_pulse_end", {ic_ready, dc_ready, mem_req, busy}, 0);
  endtask
  typedef struct {
    logic ic, dc, we;
    logic [31:0] ia, da;
    logic [127:0] wd, rd;
    int lat;
    logic exp_d;
    logic [31:0] exp_addr;
    logic exp_we;
  } vec_t;
  vec_t vt[7];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int rises[$];
    logic gnts[$];
    logic prev;
    int n;
    logic p_ic, p_dc, we, d;
    logic [31:0] ia, da;
    logic [127:0] wd;
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_104C, 32'h0, 128'h0, {4{32'hDEADBEEF}}, 3, 1'b0, 32'h0000_1040, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_104C, 32'h0000_2000, 128'h0, {4{32'hA5A5A5A5}}, 1, 1'b1, 32'h0000_2000, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_104C, 32'h0000_2000, 128'h0, {4{32'hC3C3C3C3}}, 2, 1'b0, 32'h0000_1040, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_104C, 32'h0000_2000, 128'h0, {4{32'h5A5A5A5A}}, 0, 1'b1, 32'h0000_2000, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_104C, 32'h0, 128'h0, {4{32'h0F0F0F0F}}, 1, 1'b0, 32'h0000_1040, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_3008, {4{32'h11111111}}, {4{32'h99999999}}, 2, 1'b1, 32'h0000_3000, 1'b1};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 128'h0, {4{32'h76543210}}, 0, 1'b0, 32'hFFFF_FFF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_zero", |{mem_req, mem_we, mem_addr, mem_wdata, ic_ready, dc_ready, ic_line, dc_line, busy}, 0);
    end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_zero", |{mem_req, mem_we, mem_addr, mem_wdata, ic_ready, dc_ready, ic_line, dc_line, busy}, 0);
    end
    for (int i = 0; i < 7; i++)
      txn(vt[i].ic, vt[i].dc, vt[i].we, vt[i].ia, vt[i].da, vt[i].wd, vt[i].rd, vt[i].lat,
          vt[i].exp_d, vt[i].exp_addr, vt[i].exp_we);
    // Continuous conflicting requests at L=0 with junk completions whenever memory is idle
    ic_req = 1; dc_req = 1; dc_we = 0; ic_addr = 32'h0000_4000; dc_addr = 32'h0000_8000;
    mem_lat = 0; mem_line = {4{32'h13572468}}; spur = 1; prev = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (mem_req && !prev) rises.push_back(i);
      if (ic_ready) gnts.push_back(1'b0);
      if (dc_ready) gnts.push_back(1'b1);
      prev = mem_req;
    end
    ic_req = 0; dc_req = 0;
    chk("spacing_count", rises.size(), 5);
    for (int i = 1; i < rises.size(); i++) chk("spacing", rises[i] - rises[i-1], 3);
    chk("grant_count", gnts.size(), 5);
    for (int i = 0; i < gnts.size(); i++) begin
      chk("alternate", gnts[i], (i % 2 == 0) ? !m_last : m_last);
    end
    if (gnts.size() > 0) m_last = gnts[gnts.size()-1];
    m_ic_line = mem_line; m_dc_line = mem_line;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spurious_idle", {mem_req, busy, ic_ready, dc_ready}, 0);
    end
    chk("spurious_ic_line", ic_line, m_ic_line);
    chk("spurious_dc_line", dc_line, m_dc_line);
    spur = 0;
    // Reset asserted while a transaction is in flight
    ic_req = 1; ic_addr = 32'h0000_5004; mem_lat = 10; mem_line = {4{32'hCAFEF00D}};
    n = 0;
    while (!mem_req && n < 8) begin @(negedge clk); n++; end
    chk("rst_busy_started", mem_req, 1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_async_mem_req", {mem_req, busy}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_no_ready", {ic_ready, dc_ready, ic_line != 0, dc_line != 0}, 0);
    end
    m_last = 0; m_ic_line = 0; m_dc_line = 0;
    rst = 1;
    txn(1'b1, 1'b0, 1'b0, 32'h0000_5004, 32'h0, 128'h0, {4{32'h2468ACE0}}, 2, 1'b0, 32'h0000_5000, 1'b0);
    p_ic = 0; p_dc = 0; ia = 0; da = 0; we = 0; wd = 0;
    for (int i = 0; i < 40; i++) begin
      if (!p_ic) begin p_ic = 1'($urandom_range(0, 1)); ia = $urandom; end
      if (!p_dc) begin
        p_dc = 1'($urandom_range(0, 1)); da = $urandom; we = 1'($urandom_range(0, 1));
        wd = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!p_ic && !p_dc) p_ic = 1;
      d = p_dc && (!p_ic || !m_last);
      txn(p_ic, p_dc, we, ia, da, wd, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 4),
          d, (d ? da : ia) & 32'hFFFF_FFF0, d & we);
      if (d) p_dc = 0; else p_ic = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory line port between the instruction cache and the data cache. It accepts level-held miss requests from both caches and grants them one at a time, with round-robin on conflicts. It drives one memory transaction per grant and returns the line to the granted cache with a one-cycle ready pulse. It sits between the two cache blocks and the memory model, in place of a direct cache-to-memory connection.

## Interface
- ADDR_W, 32 (`WORD_SIZE): address width.
- LINE_W, 128 (`CACHE_LINE_SIZE): line width.
- OFF_W, 4: byte-offset bits within a line. Low OFF_W address bits are zeroed on the memory side.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ic_req  in  1  iCache miss request, held high until ic_ready.
- ic_addr  in  ADDR_W  iCache miss address.
- ic_ready  out  1  one-cycle pulse: ic_line is valid.
- ic_line  out  LINE_W  line returned to iCache.
- dc_req  in  1  dCache request, held high until dc_ready.
- dc_we  in  1  1 = line write, 0 = line read.
- dc_addr  in  ADDR_W  dCache address.
- dc_wdata  in  LINE_W  write line, valid with dc_req & dc_we.
- dc_ready  out  1  one-cycle pulse: read data valid or write done.
- dc_line  out  LINE_W  line returned to dCache.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  write transaction.
- mem_addr  out  ADDR_W  line-aligned address.
- mem_wdata  out  LINE_W  write data.
- mem_ready  in  1  memory completion, one cycle.
- mem_rdata  in  LINE_W  read line, valid with mem_ready.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one of ic_req/dc_req high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - On a grant: latch granted address with the low OFF_W bits cleared, plus we (0 for iCache) and wdata into mem_addr/mem_we/mem_wdata; set grant; go to BUSY.
- BUSY:
  - mem_req=1, and mem_addr/mem_we/mem_wdata are held stable.
  - mem_ready=1: latch mem_rdata into the granted requester's line register (reads only; writes leave it unchanged); go to DONE.
- DONE:
  - mem_req=0.
  - Pulse the granted requester's ready for exactly this cycle.
  - last_grant <= grant.
  - Go to IDLE.
  - Requests are ignored in DONE. A requester drops req no later than the cycle it sees its ready.
- mem_ready is ignored in IDLE and DONE.
- Request inputs are sampled only in IDLE. Changes to address or data while BUSY have no effect.
- ic_line and dc_line hold their last returned line until the next read completes for that requester.
- Reset values:
  - state = IDLE; last_grant = I, so dCache wins the first conflict.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, ic_ready, dc_ready, ic_line, dc_line, busy.
- Reset asserted mid-transaction: the transaction is abandoned, mem_req drops asynchronously, and no ready pulse is issued. Requesters re-request after reset.

## Timing
- Request seen high in IDLE at edge N: mem_req high from cycle N+1.
- mem_ready at cycle N+1+L (L ≥ 0, L=0 means same cycle as the first mem_req): ready pulse in cycle N+2+L. Earliest next grant at edge N+3+L.
- Minimum spacing between transactions: 3 cycles (IDLE, BUSY, DONE).
- Back-to-back conflicts alternate grants: D, I, D, I...
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared constants.v: `WORD_SIZE, `CACHE_LINE_SIZE, new `LINE_OFF_BITS, FSM state encodings `ARB_IDLE/`ARB_BUSY/`ARB_DONE, grant encodings `GNT_I/`GNT_D.
- One sub-module: arb_rr2, a combinational two-way round-robin picker (inputs: req[1:0], last; outputs: gnt[1:0]).
- Everything else is flat in mem_arbiter.

## Test plan
- Reset then idle: all outputs 0 and busy=0 for 5 cycles. Release reset, assert nothing: still all 0.
- iCache only: ic_addr=0x0000_104C, memory L=3, mem_rdata=0xDEADBEEF_...: mem_addr=0x0000_1040, mem_we=0 from N+1; ic_ready pulses at N+5 with that line. dc_ready never pulses.
- Simultaneous ic_req and dc_req (dc read 0x2000) right after reset: dCache granted first, iCache second. Three alternating conflicts are granted D, I, D.
- dCache write: dc_we=1, dc_addr=0x3008, dc_wdata=0x1111...: mem_we=1, mem_addr=0x3000, mem_wdata matches; dc_ready pulses. dc_line is unchanged from its previous value.
- L=0 memory with continuous requests: transactions spaced exactly 3 cycles apart. Spurious mem_ready in IDLE or DONE causes no state change.
- Reset asserted in BUSY: mem_req falls immediately, no ready pulse. After release, the held request is re-granted from IDLE.
